// File: rtl/exu_muldiv.sv
// Execute-stage ALU with an iterative M-extension unit.
// Single-cycle integer ops produce a registered result one cycle after
// accept; multiply/divide run one bit per cycle for XLEN cycles on
// magnitudes, then the signed result is presented for one DONE cycle.
module exu_muldiv #(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [1:0]      alu_op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Two's-complement negation at datapath width.
  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return {XLEN{1'b0}} - v;
  endfunction

  // Two's-complement negation of a full-width product.
  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
    return {(2*XLEN){1'b0}} - v;
  endfunction

  state_t            state_r, state_nx;
  logic              accept_s, is_m_s, last_s;
  logic [XLEN-1:0]   alu_res_s;
  logic [SHW-1:0]    shamt_s;

  logic              sgn_a_s, sgn_b_s, neg_a_s, neg_b_s, neg_res_s;
  logic [XLEN-1:0]   abs_a_s, abs_b_s;

  logic [XLEN:0]     hi_r;
  logic [XLEN-1:0]   lo_r, opnd_r, a_r;
  logic [2:0]        op_r;
  logic              neg_r, divz_r;
  logic [CW-1:0]     cnt_r;

  logic [XLEN:0]     mul_sum_s, div_shift_s, step_hi_s;
  logic              div_ge_s;
  logic [XLEN-1:0]   step_lo_s;
  logic [2*XLEN-1:0] prod_s, prod_fix_s;
  logic [XLEN-1:0]   quo_fix_s, rem_fix_s, final_s;

  logic              out_valid_r;
  logic [XLEN-1:0]   out_result_r;

  assign in_ready   = (state_r == ST_IDLE);
  assign busy       = (state_r == ST_BUSY) || (state_r == ST_DONE);
  assign accept_s   = in_valid && in_ready && !flush;
  assign last_s     = (state_r == ST_BUSY) && (cnt_r == CNT_LAST);
  assign shamt_s    = src_b[SHW-1:0];
  assign is_m_s     = (ENABLE_M != 32'sd0) && (alu_op == 2'b10) &&
                      (opcode == 7'b0110011) && (funct7 == 7'b0000001);
  assign out_valid  = out_valid_r;
  assign out_result = out_result_r;

  // Single-cycle ALU decode and evaluation from the offered operation.
  always_comb begin
    alu_res_s = src_a + src_b;
    case (alu_op)
      2'b00: alu_res_s = src_a + src_b;
      2'b01: alu_res_s = src_a - src_b;
      2'b11: begin
        if (funct3 == 3'b101) begin
          alu_res_s = src_b;
        end else begin
          alu_res_s = src_a + src_b;
        end
      end
      2'b10: begin
        case (funct3)
          3'b000: begin
            // JALR shares funct3=000 with ADD but never subtracts
            if (opcode[5] && funct7[5] && (opcode != 7'b1100111)) begin
              alu_res_s = src_a - src_b;
            end else begin
              alu_res_s = src_a + src_b;
            end
          end
          3'b001: alu_res_s = src_a << shamt_s;
          3'b101: begin
            if (funct7[5]) begin
              alu_res_s = $signed(src_a) >>> shamt_s;
            end else begin
              alu_res_s = src_a >> shamt_s;
            end
          end
          3'b010: alu_res_s = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
          3'b011: alu_res_s = {{(XLEN-1){1'b0}}, (src_a < src_b)};
          3'b100: alu_res_s = src_a ^ src_b;
          3'b110: alu_res_s = src_a | src_b;
          3'b111: alu_res_s = src_a & src_b;
          default: alu_res_s = src_a + src_b;
        endcase
      end
      default: alu_res_s = src_a + src_b;
    endcase
  end

  // Operand signedness, magnitudes and final sign for the M op being offered.
  always_comb begin
    sgn_a_s = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
              (funct3 == F3_DIV)  || (funct3 == F3_REM);
    sgn_b_s = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    neg_a_s = sgn_a_s && src_a[XLEN-1];
    neg_b_s = sgn_b_s && src_b[XLEN-1];
    if (neg_a_s) begin
      abs_a_s = neg_x(src_a);
    end else begin
      abs_a_s = src_a;
    end
    if (neg_b_s) begin
      abs_b_s = neg_x(src_b);
    end else begin
      abs_b_s = src_b;
    end
    // remainder takes the dividend's sign, everything else the product of signs
    if (funct3 == F3_REM) begin
      neg_res_s = neg_a_s;
    end else begin
      neg_res_s = neg_a_s ^ neg_b_s;
    end
  end

  // One iteration: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum_s   = hi_r;
    div_shift_s = {hi_r[XLEN-1:0], lo_r[XLEN-1]};
    div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
    if (lo_r[0]) begin
      mul_sum_s = hi_r + {1'b0, opnd_r};
    end else begin
      mul_sum_s = hi_r;
    end
    if (op_r[2]) begin
      if (div_ge_s) begin
        step_hi_s = div_shift_s - {1'b0, opnd_r};
      end else begin
        step_hi_s = div_shift_s;
      end
      step_lo_s = {lo_r[XLEN-2:0], div_ge_s};
    end else begin
      step_hi_s = {1'b0, mul_sum_s[XLEN:1]};
      step_lo_s = {mul_sum_s[0], lo_r[XLEN-1:1]};
    end
  end

  // Sign correction and result selection from the last iteration's values.
  always_comb begin
    prod_s = {step_hi_s[XLEN-1:0], step_lo_s};
    if (neg_r) begin
      prod_fix_s = neg_2x(prod_s);
      quo_fix_s  = neg_x(step_lo_s);
      rem_fix_s  = neg_x(step_hi_s[XLEN-1:0]);
    end else begin
      prod_fix_s = prod_s;
      quo_fix_s  = step_lo_s;
      rem_fix_s  = step_hi_s[XLEN-1:0];
    end
    case (op_r)
      F3_MUL:                        final_s = prod_fix_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  final_s = prod_fix_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU: begin
        if (divz_r) begin
          final_s = {XLEN{1'b1}};
        end else begin
          final_s = quo_fix_s;
        end
      end
      F3_REM, F3_REMU: begin
        if (divz_r) begin
          final_s = a_r;
        end else begin
          final_s = rem_fix_s;
        end
      end
      default: final_s = {XLEN{1'b0}};
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // FSM next state: flush wins from any state.
  always_comb begin
    state_nx = state_r;
    if (flush) begin
      state_nx = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && is_m_s) begin
            state_nx = ST_BUSY;
          end else begin
            state_nx = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (cnt_r == CNT_LAST) begin
            state_nx = ST_DONE;
          end else begin
            state_nx = ST_BUSY;
          end
        end
        ST_DONE: state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Operand capture, iteration registers and registered result/valid.
  // The finished M result is written on the edge into DONE so it is
  // presented from a register for the whole DONE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r         <= {(XLEN+1){1'b0}};
      lo_r         <= {XLEN{1'b0}};
      opnd_r       <= {XLEN{1'b0}};
      a_r          <= {XLEN{1'b0}};
      op_r         <= 3'b000;
      neg_r        <= 1'b0;
      divz_r       <= 1'b0;
      cnt_r        <= CNT_ZERO;
      out_valid_r  <= 1'b0;
      out_result_r <= {XLEN{1'b0}};
    end else begin
      out_valid_r <= 1'b0;
      if (flush) begin
        cnt_r <= CNT_ZERO;
      end else if (accept_s) begin
        if (is_m_s) begin
          op_r   <= funct3;
          neg_r  <= neg_res_s;
          divz_r <= (src_b == {XLEN{1'b0}});
          a_r    <= src_a;
          cnt_r  <= CNT_ZERO;
          hi_r   <= {(XLEN+1){1'b0}};
          if (funct3[2]) begin
            lo_r   <= abs_a_s;
            opnd_r <= abs_b_s;
          end else begin
            lo_r   <= abs_b_s;
            opnd_r <= abs_a_s;
          end
        end else begin
          out_result_r <= alu_res_s;
          out_valid_r  <= 1'b1;
        end
      end else if (state_r == ST_BUSY) begin
        hi_r  <= step_hi_s;
        lo_r  <= step_lo_s;
        cnt_r <= cnt_r + CNT_ONE;
        if (last_s) begin
          out_result_r <= final_s;
          out_valid_r  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_exu_muldiv.sv
// Directed bench for exu_muldiv: a vector table of single ops on a 32-bit
// and a 64-bit instance, plus hand sequences for busy/flush/reset corners.
module tb_exu_muldiv;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] F7_0    = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
  localparam logic [6:0] F7_M    = 7'b0000001;

  typedef struct {
    string       name;
    logic [1:0]  alu_op;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
    bit          is64;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [1:0]  alu_op;
  logic        in_valid32, in_valid64;
  logic [31:0] src_a32, src_b32;
  logic [63:0] src_a64, src_b64;
  logic        in_ready32, out_valid32, busy32;
  logic [31:0] out_result32;
  logic        in_ready64, out_valid64, busy64;
  logic [63:0] out_result64;

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];

  exu_muldiv #(.XLEN(32), .ENABLE_M(1)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid32), .in_ready(in_ready32),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .alu_op(alu_op),
    .src_a(src_a32), .src_b(src_b32), .flush(flush),
    .out_valid(out_valid32), .out_result(out_result32), .busy(busy32)
  );

  exu_muldiv #(.XLEN(64), .ENABLE_M(1)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid64), .in_ready(in_ready64),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .alu_op(alu_op),
    .src_a(src_a64), .src_b(src_b64), .flush(flush),
    .out_valid(out_valid64), .out_result(out_result64), .busy(busy64)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [1:0] ao, input logic [6:0] op,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] e, input int lat, input bit w64);
    vec_t v;
    v.name = n; v.alu_op = ao; v.opcode = op; v.funct3 = f3; v.funct7 = f7;
    v.a = a; v.b = b; v.exp = e; v.lat = lat; v.is64 = w64;
    return v;
  endfunction

  task automatic drive_fields(input logic [1:0] ao, input logic [6:0] op,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [63:0] a, input logic [63:0] b);
    alu_op = ao; opcode = op; funct3 = f3; funct7 = f7;
    src_a32 = a[31:0]; src_b32 = b[31:0]; src_a64 = a; src_b64 = b;
  endtask

  // Offer one op, measure cycles to out_valid, check result and pulse width.
  task automatic run_vec(input vec_t v);
    int cyc;
    logic vld;
    logic [63:0] res;
    drive_fields(v.alu_op, v.opcode, v.funct3, v.funct7, v.a, v.b);
    in_valid32 = !v.is64;
    in_valid64 = v.is64;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    in_valid64 = 1'b0;
    cyc = 1;
    vld = v.is64 ? out_valid64 : out_valid32;
    while (!vld && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      vld = v.is64 ? out_valid64 : out_valid32;
    end
    res = v.is64 ? out_result64 : {32'h0, out_result32};
    check({v.name, " latency"}, 64'(cyc), 64'(v.lat));
    check({v.name, " result"}, res, v.exp);
    @(posedge clk); #1;
    vld = v.is64 ? out_valid64 : out_valid32;
    check({v.name, " pulse"}, {63'h0, vld}, 64'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    reset = 1'b1; flush = 1'b0; in_valid32 = 1'b0; in_valid64 = 1'b0;
    drive_fields(2'b00, OP_R, 3'b000, F7_0, 64'h0, 64'h0);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", {63'h0, out_valid32}, 64'h0);
    check("rst out_result", {32'h0, out_result32}, 64'h0);
    check("rst busy", {63'h0, busy32}, 64'h0);
    check("rst in_ready", {63'h0, in_ready32}, 64'h1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post-rst in_ready", {63'h0, in_ready32}, 64'h1);

    // vector table
    vecs.push_back(mk("add",     2'b10, OP_R, 3'b000, F7_0,   64'd5, 64'd7, 64'd12, 1, 0));
    vecs.push_back(mk("sub",     2'b10, OP_R, 3'b000, F7_SUB, 64'd5, 64'd7, 64'hFFFFFFFE, 1, 0));
    vecs.push_back(mk("ao00",    2'b00, OP_R, 3'b101, F7_SUB, 64'd3, 64'd4, 64'd7, 1, 0));
    vecs.push_back(mk("ao01",    2'b01, OP_R, 3'b000, F7_0,   64'd10, 64'd3, 64'd7, 1, 0));
    vecs.push_back(mk("csrrwi",  2'b11, OP_R, 3'b101, F7_0,   64'd1, 64'hABCD, 64'hABCD, 1, 0));
    vecs.push_back(mk("ao11add", 2'b11, OP_R, 3'b001, F7_0,   64'd2, 64'd2, 64'd4, 1, 0));
    vecs.push_back(mk("jalr",    2'b10, OP_JALR, 3'b000, F7_SUB, 64'd5, 64'd7, 64'd12, 1, 0));
    vecs.push_back(mk("addi",    2'b10, OP_I, 3'b000, F7_SUB, 64'd5, 64'd7, 64'd12, 1, 0));
    vecs.push_back(mk("sll",     2'b10, OP_R, 3'b001, F7_0,   64'd1, 64'h24, 64'd16, 1, 0));
    vecs.push_back(mk("sra",     2'b10, OP_R, 3'b101, F7_SUB, 64'h80000000, 64'd4, 64'hF8000000, 1, 0));
    vecs.push_back(mk("srl",     2'b10, OP_R, 3'b101, F7_0,   64'h80000000, 64'd4, 64'h08000000, 1, 0));
    vecs.push_back(mk("slt",     2'b10, OP_R, 3'b010, F7_0,   64'hFFFFFFFF, 64'd1, 64'd1, 1, 0));
    vecs.push_back(mk("sltu",    2'b10, OP_R, 3'b011, F7_0,   64'hFFFFFFFF, 64'd1, 64'd0, 1, 0));
    vecs.push_back(mk("xor",     2'b10, OP_R, 3'b100, F7_0,   64'hF0F0, 64'h0FF0, 64'hFF00, 1, 0));
    vecs.push_back(mk("or",      2'b10, OP_R, 3'b110, F7_0,   64'hF000, 64'h000F, 64'hF00F, 1, 0));
    vecs.push_back(mk("and",     2'b10, OP_R, 3'b111, F7_0,   64'hFF0F, 64'h0FF0, 64'h0F00, 1, 0));
    vecs.push_back(mk("div",     2'b10, OP_R, 3'b100, F7_M, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFD, 33, 0));
    vecs.push_back(mk("rem",     2'b10, OP_R, 3'b110, F7_M, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFF, 33, 0));
    vecs.push_back(mk("divu0",   2'b10, OP_R, 3'b101, F7_M, 64'h1234, 64'd0, 64'hFFFFFFFF, 33, 0));
    vecs.push_back(mk("remu0",   2'b10, OP_R, 3'b111, F7_M, 64'h1234, 64'd0, 64'h1234, 33, 0));
    vecs.push_back(mk("divovf",  2'b10, OP_R, 3'b100, F7_M, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 33, 0));
    vecs.push_back(mk("removf",  2'b10, OP_R, 3'b110, F7_M, 64'h80000000, 64'hFFFFFFFF, 64'h0, 33, 0));
    vecs.push_back(mk("mulhu",   2'b10, OP_R, 3'b011, F7_M, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 33, 0));
    vecs.push_back(mk("mul",     2'b10, OP_R, 3'b000, F7_M, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h1, 33, 0));
    vecs.push_back(mk("mulhsu",  2'b10, OP_R, 3'b010, F7_M, 64'hFFFFFFFF, 64'd2, 64'hFFFFFFFF, 33, 0));
    vecs.push_back(mk("mulh",    2'b10, OP_R, 3'b001, F7_M, 64'h80000000, 64'h80000000, 64'h40000000, 33, 0));
    vecs.push_back(mk("div0s",   2'b10, OP_R, 3'b100, F7_M, 64'hFFFFFFFB, 64'd0, 64'hFFFFFFFF, 33, 0));
    vecs.push_back(mk("rem0s",   2'b10, OP_R, 3'b110, F7_M, 64'hFFFFFFFB, 64'd0, 64'hFFFFFFFB, 33, 0));
    vecs.push_back(mk("divu",    2'b10, OP_R, 3'b101, F7_M, 64'd100, 64'd7, 64'd14, 33, 0));
    vecs.push_back(mk("remu",    2'b10, OP_R, 3'b111, F7_M, 64'd100, 64'd7, 64'd2, 33, 0));
    vecs.push_back(mk("remneg",  2'b10, OP_R, 3'b110, F7_M, 64'd7, 64'hFFFFFFFE, 64'd1, 33, 0));
    vecs.push_back(mk("add64",   2'b10, OP_R, 3'b000, F7_0,   64'd5, 64'd7, 64'd12, 1, 1));
    vecs.push_back(mk("sub64",   2'b10, OP_R, 3'b000, F7_SUB, 64'd5, 64'd7, 64'hFFFFFFFFFFFFFFFE, 1, 1));
    vecs.push_back(mk("div64",   2'b10, OP_R, 3'b100, F7_M, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 65, 1));
    vecs.push_back(mk("rem64",   2'b10, OP_R, 3'b110, F7_M, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 65, 1));
    vecs.push_back(mk("mulhu64", 2'b10, OP_R, 3'b011, F7_M, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 65, 1));

    foreach (vecs[i]) run_vec(vecs[i]);

    // DIV with in_ready/busy watched and operands disturbed while busy
    drive_fields(2'b10, OP_R, 3'b100, F7_M, 64'hFFFFFFF9, 64'd2);
    in_valid32 = 1'b1;
    @(posedge clk); #1;
    cnt = 0;
    for (int c = 1; c <= 32; c++) begin
      if (in_ready32 || !busy32 || out_valid32) cnt++;
      src_a32 = $urandom;
      src_b32 = $urandom;
      funct3 = 3'($urandom_range(0, 7));
      if (c < 32) begin
        @(posedge clk); #1;
      end
    end
    in_valid32 = 1'b0;
    check("busy window cycles wrong", 64'(cnt), 64'h0);
    @(posedge clk); #1;
    check("busy div valid@33", {63'h0, out_valid32}, 64'h1);
    check("busy div result", {32'h0, out_result32}, 64'hFFFFFFFD);
    check("busy in DONE", {63'h0, busy32}, 64'h1);
    @(posedge clk); #1;
    check("ready after DONE", {63'h0, in_ready32}, 64'h1);
    check("result hold", {32'h0, out_result32}, 64'hFFFFFFFD);

    // flush in cycle 10 of a DIV, then an add in the following cycle
    drive_fields(2'b10, OP_R, 3'b100, F7_M, 64'd100, 64'd3);
    in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    cnt = 0;
    for (int c = 2; c <= 10; c++) begin
      @(posedge clk); #1;
      if (out_valid32) cnt++;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush in_ready", {63'h0, in_ready32}, 64'h1);
    check("flush busy", {63'h0, busy32}, 64'h0);
    drive_fields(2'b10, OP_R, 3'b000, F7_0, 64'd20, 64'd22);
    in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    check("post-flush add valid", {63'h0, out_valid32}, 64'h1);
    check("post-flush add result", {32'h0, out_result32}, 64'd42);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid32) cnt++;
    end
    check("flushed div valids", 64'(cnt), 64'h0);

    // flush together with in_valid: nothing accepted, result held
    drive_fields(2'b10, OP_R, 3'b100, F7_M, 64'd9, 64'd3);
    in_valid32 = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    flush = 1'b0;
    check("flush+valid no valid", {63'h0, out_valid32}, 64'h0);
    check("flush+valid no busy", {63'h0, busy32}, 64'h0);
    check("flush+valid hold", {32'h0, out_result32}, 64'd42);

    // back-to-back single-cycle ops
    drive_fields(2'b00, OP_R, 3'b000, F7_0, 64'd1, 64'd1);
    in_valid32 = 1'b1;
    @(posedge clk); #1;
    check("b2b first valid", {63'h0, out_valid32}, 64'h1);
    check("b2b first result", {32'h0, out_result32}, 64'd2);
    drive_fields(2'b00, OP_R, 3'b000, F7_0, 64'd2, 64'd3);
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    check("b2b second valid", {63'h0, out_valid32}, 64'h1);
    check("b2b second result", {32'h0, out_result32}, 64'd5);

    // reset pulsed mid-BUSY on both widths
    drive_fields(2'b10, OP_R, 3'b100, F7_M, 64'd1000, 64'd7);
    in_valid32 = 1'b1;
    in_valid64 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    in_valid64 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("async rst busy32", {63'h0, busy32}, 64'h0);
    check("async rst result32", {32'h0, out_result32}, 64'h0);
    check("async rst busy64", {63'h0, busy64}, 64'h0);
    check("async rst ready64", {63'h0, in_ready64}, 64'h1);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst release ready32", {63'h0, in_ready32}, 64'h1);
    cnt = 0;
    for (int c = 0; c < 80; c++) begin
      if (out_valid32 || out_valid64) cnt++;
      @(posedge clk); #1;
    end
    check("stale valid after rst", 64'(cnt), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exu_muldiv.md
EXU_MULDIV -- requirements
Module: exu_muldiv

Interface
REQ-001 Parameter XLEN, default 32, sets the datapath width; legal values are 32 and 64.
REQ-002 Parameter ENABLE_M, default 1, enables the M-extension path; at 0, M encodings decode as plain ALU ops (add/sub rules).
REQ-003 Ports, in order (name, direction, width, meaning):
- clk, in, 1, single clock.
- reset, in, 1, asynchronous, active-high.
- in_valid, in, 1, operation offered.
- in_ready, out, 1, unit can accept.
- opcode, in, 7, instruction opcode.
- funct3, in, 3, instruction funct3.
- funct7, in, 7, instruction funct7.
- alu_op, in, 2, main-decoder class.
- src_a, in, XLEN, operand A.
- src_b, in, XLEN, operand B.
- flush, in, 1, kill the in-flight operation.
- out_valid, out, 1, result pulse.
- out_result, out, XLEN, result.
- busy, out, 1, multi-cycle operation in progress.

Function
REQ-004 An operation is accepted in a cycle where in_valid=1, in_ready=1 and flush=0.
REQ-005 in_ready is 1 only in state IDLE; it is combinational from state only.
REQ-006 Decode at accept:
- alu_op=00 -> add.
- alu_op=01 -> sub.
- alu_op=11 with funct3=101 -> pass src_b (CSRRWI).
- other alu_op=11 -> add.
REQ-007 alu_op=10 with M-encoding (opcode=0110011, funct7=0000001, ENABLE_M=1) -> M op by funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-008 alu_op=10 otherwise, by funct3:
- 000 -> sub when opcode[5]=1 and funct7[5]=1, else add; opcode 1100111 is always add.
- 001 -> sll; 101 -> sra when funct7[5]=1, else srl.
- 010 -> slt (signed); 011 -> sltu.
- 100 -> xor; 110 -> or; 111 -> and.
REQ-009 Shift amount is src_b[log2(XLEN)-1:0]; slt and sltu results are zero-extended 0/1.
REQ-010 Non-M ops: the result is registered; out_valid=1 for exactly one cycle, the cycle after accept; the FSM stays IDLE, so back-to-back accepts are permitted.
REQ-011 M ops: FSM IDLE->BUSY at accept; BUSY runs an iterative shift-add (multiply) or restoring (divide) step of 1 bit per cycle for XLEN cycles, then BUSY->DONE; DONE asserts out_valid for 1 cycle and returns to IDLE.
REQ-012 M-op latency: out_valid is exactly XLEN+1 cycles after the accept cycle; next accept is possible in the DONE cycle+1.
REQ-013 Operand registers capture src_a and src_b at accept; input changes during BUSY have no effect.
REQ-014 Signed ops take absolute values and apply the sign correction in the DONE cycle.
REQ-015 MULH variants return product bits [2*XLEN-1:XLEN]; MUL returns bits [XLEN-1:0].
REQ-016 Divide by zero: DIV and DIVU return all-ones; REM and REMU return src_a; still XLEN+1 latency.
REQ-017 Signed overflow (src_a = -2^(XLEN-1), src_b = -1): DIV returns src_a, REM returns 0.
REQ-018 busy=1 exactly in BUSY and DONE.
REQ-019 flush=1 in any state -> FSM IDLE next cycle and no out_valid for the killed op; a pending non-M out_valid in the cycle after flush is suppressed.
REQ-020 flush and in_valid asserted together -> no accept.
REQ-021 out_result holds its last value when out_valid=0.

Reset
REQ-022 reset=1 -> state IDLE, out_valid=0, out_result=0, busy=0, all datapath registers 0, asynchronously.
REQ-023 Reset released mid-operation resumes in IDLE with no stale out_valid; in_ready=1 in the first cycle after release.

Verification
REQ-024 add, alu_op=10, funct3=000, src_a=5, src_b=7 -> out_valid one cycle later, result 12; sub form (opcode 0110011, funct7=0100000) -> result 0xFFFFFFFE.
REQ-025 DIV, src_a=-7, src_b=2, XLEN=32 -> out_valid at cycle 33 after accept, result 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; in_ready=0 for cycles 1-32.
REQ-026 DIVU by 0, src_a=0x1234 -> result 0xFFFFFFFF; REMU -> 0x1234; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
REQ-027 MULHU, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MUL same -> 0x00000001; MULHSU, -1 x 2 -> 0xFFFFFFFF.
REQ-028 flush at cycle 10 of a DIV -> no out_valid, in_ready=1 next cycle; new add accepted there -> correct result one cycle later.
REQ-029 reset pulsed during BUSY -> outputs 0 immediately (no clock edge); repeat REQ-024 and REQ-025 with XLEN=64, where M-op latency is 65.
